dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the core's single-port data memory between two requesters: the core datapath (load/store) and the debug/testbench dump port.
- The debug port drives the existing tb_mem_read / tb_addr / refused path.
- Arbitrates each cycle, drives the memory, and routes 1-cycle-latency read data back to the winner.
- Core normally wins. A starvation counter guarantees debug forward progress. After halt, debug has absolute priority so a full 1024-word dump completes at one word per cycle.

Parameters:
- A_WIDTH, 10, data memory address width (1024 words)
- D_WIDTH, 12, data word width
- STARVE_LIMIT, 4, consecutive refused debug cycles before debug is forced to win (1..15)

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- halted_i  in  1  core controller is in sHalt
- core_req_i  in  1  core memory access request
- core_we_i  in  1  core write (1) / read (0)
- core_addr_i  in  A_WIDTH  core address
- core_wdata_i  in  D_WIDTH  core write data
- core_gnt_o  out  1  core access accepted this cycle
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  D_WIDTH  core read data
- dbg_req_i  in  1  debug read request (tb_mem_read)
- dbg_addr_i  in  A_WIDTH  debug address (tb_addr)
- dbg_gnt_o  out  1  debug access accepted this cycle
- dbg_refused_o  out  1  dbg_req_i high and not granted
- dbg_rvalid_o  out  1  debug read data valid
- dbg_rdata_o  out  D_WIDTH  debug read data (dmem_out)
- mem_en_o  out  1  memory enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  A_WIDTH  memory address
- mem_wdata_o  out  D_WIDTH  memory write data
- mem_rdata_i  in  D_WIDTH  memory read data, valid the cycle after a read enable

Behaviour:
- Debug port is read-only. Writes come only from the core.
- Grant logic is combinational in the same cycle:
  - dbg_win = dbg_req_i & (halted_i | ~core_req_i | starve_cnt == STARVE_LIMIT)
  - core_win = core_req_i & ~dbg_win
  - At most one grant is high per cycle.
- Memory drive:
  - mem_en_o = core_win | dbg_win.
  - mem_we_o = core_win & core_we_i.
  - mem_addr_o / mem_wdata_o come from the winner.
  - When idle: mem_addr_o = 0, mem_wdata_o = 0.
- Refused requesters must hold their request and address stable until granted.
  - core_gnt_o low is a stall to the core controller.
  - The block does not queue requests.
- Starvation counter starve_cnt (4 bits):
  - On rising edge: reset to 0 if dbg_win or ~dbg_req_i.
  - Otherwise increment if dbg_refused_o, saturating at STARVE_LIMIT.
  - Debug therefore waits at most STARVE_LIMIT cycles while the core streams requests.
- Read return registers:
  - owner_r[1:0] = {dbg_win, core_win & ~core_we_i}, captured on each edge.
  - Next cycle: core_rvalid_o = owner_r[0], dbg_rvalid_o = owner_r[1].
  - Both rdata outputs = mem_rdata_i, gated to 0 when the matching rvalid is low.
  - Read latency is exactly 1 cycle after grant; back-to-back grants give one word per cycle.
- Core writes produce no rvalid.
- Same-address read-after-write returns whatever the memory macro returns; the arbiter does not forward.
- Reset (asynchronous, any time, including mid-access):
  - starve_cnt = 0, owner_r = 0, so both rvalid = 0 and both rdata = 0.
  - Combinational outputs follow the inputs; an in-flight read's data is discarded.
- halted_i falling while debug is pending: normal priority resumes on the same cycle.

Test Plan:
- Core-only read at 0x005 (mem holds 0xABC) → core_gnt_o=1 that cycle; next cycle core_rvalid_o=1, core_rdata_o=0xABC; dbg_rvalid_o=0.
- Core write 0x3FF←0x123, then debug read 0x3FF with core idle → dbg_gnt_o=1, one cycle later dbg_rdata_o=0x123, dbg_refused_o never high.
- Core requests every cycle, debug requests 0x010 continuously, STARVE_LIMIT=4 → dbg_refused_o high exactly 4 cycles, 5th cycle dbg_gnt_o=1 and core_gnt_o=0, then starve_cnt=0 and core wins again.
- halted_i=1, debug sweeps addresses 0..1023 one per cycle with core_req_i held high → 1024 consecutive dbg_rvalid_o pulses with correct data, zero refusals, core_gnt_o=0 throughout.
- Assert reset_n_i low for half a cycle in the cycle after a core read grant → core_rvalid_o drops to 0 immediately, stays 0 after release; starve_cnt=0.
- Both requesters idle → mem_en_o=0, mem_we_o=0, all gnt/rvalid/refused=0 for 10 cycles.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - core/debug requester and data memory signals for the dmem port arbiter
interface dmem_port_arbiter_if #(
    parameter int A_WIDTH = 10,
    parameter int D_WIDTH = 12
);
    logic               halted_i;
    logic               core_req_i;
    logic               core_we_i;
    logic [A_WIDTH-1:0] core_addr_i;
    logic [D_WIDTH-1:0] core_wdata_i;
    logic               core_gnt_o;
    logic               core_rvalid_o;
    logic [D_WIDTH-1:0] core_rdata_o;
    logic               dbg_req_i;
    logic [A_WIDTH-1:0] dbg_addr_i;
    logic               dbg_gnt_o;
    logic               dbg_refused_o;
    logic               dbg_rvalid_o;
    logic [D_WIDTH-1:0] dbg_rdata_o;
    logic               mem_en_o;
    logic               mem_we_o;
    logic [A_WIDTH-1:0] mem_addr_o;
    logic [D_WIDTH-1:0] mem_wdata_o;
    logic [D_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  halted_i, core_req_i, core_we_i, core_addr_i, core_wdata_i,
        input  dbg_req_i, dbg_addr_i, mem_rdata_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        output dbg_gnt_o, dbg_refused_o, dbg_rvalid_o, dbg_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output halted_i, core_req_i, core_we_i, core_addr_i, core_wdata_i,
        output dbg_req_i, dbg_addr_i, mem_rdata_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        input  dbg_gnt_o, dbg_refused_o, dbg_rvalid_o, dbg_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the single-port data memory between the core and the debug dump port
module dmem_port_arbiter #(
    parameter int A_WIDTH      = 10,
    parameter int D_WIDTH      = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset_n_i,
    dmem_port_arbiter_if.slave   bus
);
    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]         r_starve_cnt;
    logic [1:0]         r_owner;
    logic               w_dbg_win;
    logic               w_core_win;
    logic               w_dbg_refused;
    logic [A_WIDTH-1:0] w_mem_addr;
    logic [D_WIDTH-1:0] w_mem_wdata;

    // Core wins by default; debug wins when halted, when the core is idle, or once starved long enough.
    assign w_dbg_win     = bus.dbg_req_i & (bus.halted_i | ~bus.core_req_i | (r_starve_cnt == LP_LIMIT));
    assign w_core_win    = bus.core_req_i & ~w_dbg_win;
    assign w_dbg_refused = bus.dbg_req_i & ~w_dbg_win;

    assign w_mem_addr  = w_dbg_win  ? bus.dbg_addr_i :
                         w_core_win ? bus.core_addr_i : '0;
    assign w_mem_wdata = w_core_win ? bus.core_wdata_i : '0;

    assign bus.core_gnt_o    = w_core_win;
    assign bus.dbg_gnt_o     = w_dbg_win;
    assign bus.dbg_refused_o = w_dbg_refused;
    assign bus.mem_en_o      = w_core_win | w_dbg_win;
    assign bus.mem_we_o      = w_core_win & bus.core_we_i;
    assign bus.mem_addr_o    = w_mem_addr;
    assign bus.mem_wdata_o   = w_mem_wdata;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_starve_cnt <= 4'd0;
        end else if (w_dbg_win || !bus.dbg_req_i) begin
            r_starve_cnt <= 4'd0;
        end else if (w_dbg_refused && (r_starve_cnt != LP_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Remembers who issued last cycle's read so the macro's 1-cycle data is steered to them.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_owner <= 2'b00;
        end else begin
            r_owner <= {w_dbg_win, w_core_win & ~bus.core_we_i};
        end
    end

    assign bus.core_rvalid_o = r_owner[0];
    assign bus.dbg_rvalid_o  = r_owner[1];
    assign bus.core_rdata_o  = r_owner[0] ? bus.mem_rdata_i : '0;
    assign bus.dbg_rdata_o   = r_owner[1] ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 12;

    logic clk;
    logic reset_n;
    logic load;
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] mem_rd;

    int n_vec;
    int n_miss;

    dmem_port_arbiter_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

    dmem_port_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .STARVE_LIMIT(4)) u_dut (
        .clk       (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        return 12'(i * 13 + 32'hA7B);
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        end else if (bus.mem_en_o) begin
            if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
            else              mem_rd <= mem[bus.mem_addr_o];
        end
    end
    assign bus.mem_rdata_i = mem_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic halted, input logic creq, input logic cwe,
                         input logic [AW-1:0] caddr, input logic [DW-1:0] cwdata,
                         input logic dreq, input logic [AW-1:0] daddr);
        bus.halted_i     = halted;
        bus.core_req_i   = creq;
        bus.core_we_i    = cwe;
        bus.core_addr_i  = caddr;
        bus.core_wdata_i = cwdata;
        bus.dbg_req_i    = dreq;
        bus.dbg_addr_i   = daddr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ref, n_cg, n_ng, n_rv, n_bad, n_crv, n_act;
        logic got;
        n_vec = 0;
        n_miss = 0;
        reset_n = 1'b0;
        load = 1'b1;
        drive(0, 0, 0, '0, '0, 0, '0);

        // reset state
        @(negedge clk);
        load = 1'b0;
        #1;
        chk("rst_core_rvalid", bus.core_rvalid_o, 0);
        chk("rst_dbg_rvalid", bus.dbg_rvalid_o, 0);
        chk("rst_core_rdata", bus.core_rdata_o, 0);
        chk("rst_mem_en", bus.mem_en_o, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // core-only read at 0x005
        @(negedge clk);
        drive(0, 1, 0, 10'h005, '0, 0, '0);
        #1;
        chk("crd_gnt", bus.core_gnt_o, 1);
        chk("crd_mem_we", bus.mem_we_o, 0);
        chk("crd_mem_addr", bus.mem_addr_o, 32'h005);
        @(negedge clk);
        drive(0, 0, 0, '0, '0, 0, '0);
        #1;
        chk("crd_rvalid", bus.core_rvalid_o, 1);
        chk("crd_rdata", bus.core_rdata_o, 32'hABC);
        chk("crd_dbg_rvalid", bus.dbg_rvalid_o, 0);
        chk("crd_dbg_rdata", bus.dbg_rdata_o, 0);

        // core write 0x3FF <- 0x123, then debug read
        @(negedge clk);
        drive(0, 1, 1, 10'h3FF, 12'h123, 0, '0);
        #1;
        chk("cwr_gnt", bus.core_gnt_o, 1);
        chk("cwr_mem_we", bus.mem_we_o, 1);
        chk("cwr_mem_wdata", bus.mem_wdata_o, 32'h123);
        @(negedge clk);
        drive(0, 0, 0, '0, '0, 1, 10'h3FF);
        #1;
        chk("drd_gnt", bus.dbg_gnt_o, 1);
        chk("drd_refused", bus.dbg_refused_o, 0);
        chk("cwr_no_rvalid", bus.core_rvalid_o, 0);
        @(negedge clk);
        drive(0, 0, 0, '0, '0, 0, '0);
        #1;
        chk("drd_rvalid", bus.dbg_rvalid_o, 1);
        chk("drd_rdata", bus.dbg_rdata_o, 32'h123);

        // starvation: core streams, debug refused 4 cycles then wins
        @(negedge clk);
        drive(0, 1, 0, 10'h020, '0, 1, 10'h010);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stv_refused", bus.dbg_refused_o, 1);
            chk("stv_core_gnt", bus.core_gnt_o, 1);
            @(negedge clk);
        end
        #1;
        chk("stv_dbg_gnt", bus.dbg_gnt_o, 1);
        chk("stv_core_gnt_lo", bus.core_gnt_o, 0);
        chk("stv_mem_addr", bus.mem_addr_o, 32'h010);
        chk("stv_refused_lo", bus.dbg_refused_o, 0);
        @(negedge clk);
        #1;
        chk("stv_core_again", bus.core_gnt_o, 1);
        chk("stv_refused_again", bus.dbg_refused_o, 1);
        chk("stv_dbg_rvalid", bus.dbg_rvalid_o, 1);
        chk("stv_dbg_rdata", bus.dbg_rdata_o, 32'hB4B);
        chk("stv_core_rvalid_lo", bus.core_rvalid_o, 0);
        @(negedge clk);
        drive(0, 0, 0, '0, '0, 0, '0);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;

        // halted full dump with core requesting throughout
        n_ref = 0; n_cg = 0; n_ng = 0; n_rv = 0; n_bad = 0; n_crv = 0;
        for (int i = 0; i <= 1024; i++) begin
            @(negedge clk);
            if (i < 1024) drive(1, 1, 0, 10'h020, '0, 1, 10'(i));
            else          drive(1, 0, 0, '0, '0, 0, '0);
            #1;
            if (i < 1024) begin
                if (bus.dbg_refused_o) n_ref++;
                if (bus.core_gnt_o)    n_cg++;
                if (!bus.dbg_gnt_o)    n_ng++;
            end
            if (i > 0) begin
                if (bus.dbg_rvalid_o) n_rv++;
                if (bus.dbg_rdata_o !== pat(i - 1)) n_bad++;
            end
            if (bus.core_rvalid_o) n_crv++;
        end
        chk("dump_rvalid_cnt", n_rv, 1024);
        chk("dump_bad_data", n_bad, 0);
        chk("dump_refusals", n_ref, 0);
        chk("dump_core_gnt", n_cg, 0);
        chk("dump_dbg_not_gnt", n_ng, 0);
        chk("dump_core_rvalid", n_crv, 0);

        // halt drops with debug pending: core wins immediately
        @(negedge clk);
        drive(0, 1, 0, 10'h020, '0, 1, 10'h010);
        #1;
        chk("unhalt_core_gnt", bus.core_gnt_o, 1);
        chk("unhalt_refused", bus.dbg_refused_o, 1);
        chk("unhalt_dbg_gnt", bus.dbg_gnt_o, 0);
        @(negedge clk);
        drive(0, 0, 0, '0, '0, 0, '0);

        // reset pulse in the cycle after a core read grant
        @(negedge clk);
        drive(0, 1, 0, 10'h005, '0, 1, 10'h010);
        #1;
        chk("rp_core_gnt", bus.core_gnt_o, 1);
        @(negedge clk);
        #1;
        chk("rp_rvalid_before", bus.core_rvalid_o, 1);
        reset_n = 1'b0;
        #1;
        chk("rp_rvalid_now", bus.core_rvalid_o, 0);
        chk("rp_rdata_now", bus.core_rdata_o, 0);
        #4;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rp_rvalid_after", bus.core_rvalid_o, 0);
        n_ref = 0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            if (bus.dbg_gnt_o)          got = 1'b1;
            else if (bus.dbg_refused_o) n_ref++;
        end
        chk("rp_dbg_got_gnt", got, 1);
        chk("rp_starve_from_zero", n_ref, 4);

        // both idle for 10 cycles
        @(negedge clk);
        drive(0, 0, 0, '0, '0, 0, '0);
        @(negedge clk);
        n_act = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (bus.mem_en_o || bus.mem_we_o || bus.core_gnt_o || bus.dbg_gnt_o ||
                bus.core_rvalid_o || bus.dbg_rvalid_o || bus.dbg_refused_o) n_act++;
        end
        chk("idle_activity", n_act, 0);
        chk("idle_mem_addr", bus.mem_addr_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
